top_level: RTL and testbench
============================

// Module: top_level
// PURPOSE
//   True dual-port synchronous block RAM wrapper: two independent read/write ports
//   (A, B) share one clock and one storage array of 2**ADDR_WIDTH words.
//   Top-level memory of the TDPR datapath; either port may read or write any
//   address every cycle. Collisions are resolved deterministically.
// PARAMETERS
//   DATA_WIDTH  8   word width in bits
//   ADDR_WIDTH  8   address width; depth = 2**ADDR_WIDTH words
// PORTS
//   clk         in   1           single clock; all state updates on rising edge
//   rst         in   1           synchronous, active-high reset
//   en_a        in   1           port A enable; no read/write/output update when 0
//   we_a        in   1           port A write enable (qualified by en_a)
//   addr_a      in   ADDR_WIDTH  port A word address
//   data_in_a   in   DATA_WIDTH  port A write data
//   data_out_a  out  DATA_WIDTH  port A registered read data
//   en_b        in   1           port B enable
//   we_b        in   1           port B write enable (qualified by en_b)
//   addr_b      in   ADDR_WIDTH  port B word address
//   data_in_b   in   DATA_WIDTH  port B write data
//   data_out_b  out  DATA_WIDTH  port B registered read data
// BEHAVIOUR
//   - Reset: rst=1 at a clk edge -> data_out_a = data_out_b = 0; no write occurs in
//     that cycle regardless of en/we. Array contents are NOT cleared by reset.
//   - Power-up: every array word initialised to 0 (initial/init-file), outputs 0.
//   - Read: en_x=1, we_x=0 -> data_out_x <= mem[addr_x] at the edge; 1-cycle latency.
//   - Write: en_x=1, we_x=1 -> mem[addr_x] <= data_in_x; write-first: data_out_x
//     shows the value actually stored at addr_x in the same edge.
//   - Disabled port (en_x=0): data_out_x holds its last value; we_x ignored.
//   - Both ports write same address same cycle: port A wins; mem = data_in_a;
//     port B write discarded; data_out_a = data_out_b = data_in_a.
//   - One port writes, other reads same address same cycle: reader gets the OLD
//     word (read-before-cross-write); writer sees new word (write-first).
//   - Both ports read same address: both get mem[addr], no interaction.
//   - Different addresses: ports fully independent.
//   - Addresses use full ADDR_WIDTH range; no wrap or out-of-range case exists.
//   - No X propagation: outputs always driven from registers.
// TESTING
//   1. Power-up/reset: rst=1 one cycle -> data_out_a=data_out_b=0x00; read
//      addr 0x10 on both ports after reset -> 0x00.
//   2. Port A: write 0xAA @0x01 (data_out_a=0xAA same edge), then read @0x01
//      -> data_out_a=0xAA next edge; data_out_b unchanged (en_b=0).
//   3. Port B: write 0xBB @0x02 then read @0x02 -> data_out_b=0xBB; A write
//      0xCC @0x03 and B write 0xDD @0x04 same cycle, then read -> 0xCC / 0xDD;
//      cross-read A@0x02, B@0x01 -> 0xBB / 0xAA.
//   4. Collision: A writes 0xEE, B writes 0xFF, both @0x05 same cycle -> both
//      outputs 0xEE; subsequent reads @0x05 on both ports -> 0xEE.
//   5. Read-during-cross-write: mem[0x06]=0x11; A writes 0x22 @0x06 while B reads
//      @0x06 -> data_out_b=0x11, data_out_a=0x22; next B read -> 0x22.
//   6. Enable/reset mid-op: drop en_a/en_b with we=1 -> outputs hold, memory
//      unchanged; assert rst with we_a=1 @0x01 data 0x55 -> outputs 0, mem[0x01]
//      still 0xAA on later read.

Source files
------------

// File: rtl/top_level.sv
// True dual-port synchronous RAM with one shared clock.
// Both ports can read or write any word every cycle. Reads take one cycle to appear.
// A write returns the stored word on its own port in the same cycle (write-first).
// A port that reads a word the other port is writing gets the old word.
// If both ports write the same address, port A wins on both outputs.
module top_level #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    // Power-up contents and outputs are zero; reset later clears only the outputs.
    logic [DATA_WIDTH-1:0] r_mem [Depth] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_data_out_a = '0;
    logic [DATA_WIDTH-1:0] r_data_out_b = '0;

    logic w_wr_a;
    logic w_wr_b;
    logic w_same_addr;
    logic w_collide;

    // Decode the qualified writes and detect a same-address double write.
    always_comb begin
        w_wr_a      = en_a & we_a;
        w_wr_b      = en_b & we_b;
        w_same_addr = (addr_a == addr_b);
        w_collide   = w_wr_a & w_wr_b & w_same_addr;
    end

    // Update the array and both read registers; reset suppresses all writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out_a <= '0;
            r_data_out_b <= '0;
        end else begin
            if (en_a) begin
                if (we_a) begin
                    r_mem[addr_a] <= data_in_a;
                    r_data_out_a  <= data_in_a;
                end else begin
                    // Non-blocking read returns the old word even if B writes here now.
                    r_data_out_a <= r_mem[addr_a];
                end
            end
            if (en_b) begin
                if (we_b) begin
                    if (!w_collide) begin
                        r_mem[addr_b] <= data_in_b;
                    end
                    r_data_out_b <= w_collide ? data_in_a : data_in_b;
                end else begin
                    r_data_out_b <= r_mem[addr_b];
                end
            end
        end
    end

    assign data_out_a = r_data_out_a;
    assign data_out_b = r_data_out_b;

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for the dual-port RAM top_level.
module tb_top_level;

    logic       clk;
    logic       rst;
    logic       en_a;
    logic       we_a;
    logic [7:0] addr_a;
    logic [7:0] data_in_a;
    logic [7:0] data_out_a;
    logic       en_b;
    logic       we_b;
    logic [7:0] addr_b;
    logic [7:0] data_in_b;
    logic [7:0] data_out_b;

    int checks;
    int failures;

    top_level #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_a      (en_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .data_in_a (data_in_a),
        .data_out_a(data_out_a),
        .en_b      (en_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .data_in_b (data_in_b),
        .data_out_b(data_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic we, input logic [7:0] addr,
                           input logic [7:0] din);
        en_a = en; we_a = we; addr_a = addr; data_in_a = din;
    endtask

    task automatic drive_b(input logic en, input logic we, input logic [7:0] addr,
                           input logic [7:0] din);
        en_b = en; we_b = we; addr_b = addr; data_in_b = din;
    endtask

    task automatic test_reset();
        checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL powerup: a=%h b=%h required 00/00", data_out_a, data_out_b);
        end
        // Writes requested during reset must not land.
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 8'h10, 8'h77);
        drive_b(1'b1, 1'b1, 8'h10, 8'h66);
        tick();
        rst = 1'b0;
        checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_out: a=%h b=%h required 00/00", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h10, 8'h00);
        drive_b(1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_read10: a=%h b=%h required 00/00", data_out_a, data_out_b);
        end
    endtask

    task automatic test_port_a();
        drive_a(1'b1, 1'b1, 8'h01, 8'hAA);
        drive_b(1'b0, 1'b1, 8'h01, 8'h13);
        tick();
        checks++;
        if (data_out_a !== 8'hAA || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL a_write: a=%h b=%h required AA/00", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h01, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hAA || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL a_read: a=%h b=%h required AA/00", data_out_a, data_out_b);
        end
    endtask

    task automatic test_port_b();
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b1, 1'b1, 8'h02, 8'hBB);
        tick();
        checks++;
        if (data_out_b !== 8'hBB || data_out_a !== 8'hAA) begin
            failures++;
            $display("FAIL b_write: a=%h b=%h required AA/BB", data_out_a, data_out_b);
        end
        drive_b(1'b1, 1'b0, 8'h02, 8'h00);
        tick();
        checks++;
        if (data_out_b !== 8'hBB) begin
            failures++;
            $display("FAIL b_read: b=%h required BB", data_out_b);
        end
        drive_a(1'b1, 1'b1, 8'h03, 8'hCC);
        drive_b(1'b1, 1'b1, 8'h04, 8'hDD);
        tick();
        checks++;
        if (data_out_a !== 8'hCC || data_out_b !== 8'hDD) begin
            failures++;
            $display("FAIL dual_write: a=%h b=%h required CC/DD", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h03, 8'h00);
        drive_b(1'b1, 1'b0, 8'h04, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hCC || data_out_b !== 8'hDD) begin
            failures++;
            $display("FAIL dual_read: a=%h b=%h required CC/DD", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h02, 8'h00);
        drive_b(1'b1, 1'b0, 8'h01, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hBB || data_out_b !== 8'hAA) begin
            failures++;
            $display("FAIL cross_read: a=%h b=%h required BB/AA", data_out_a, data_out_b);
        end
    endtask

    task automatic test_collision();
        drive_a(1'b1, 1'b1, 8'h05, 8'hEE);
        drive_b(1'b1, 1'b1, 8'h05, 8'hFF);
        tick();
        checks++;
        if (data_out_a !== 8'hEE || data_out_b !== 8'hEE) begin
            failures++;
            $display("FAIL collide_out: a=%h b=%h required EE/EE", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h05, 8'h00);
        drive_b(1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hEE || data_out_b !== 8'hEE) begin
            failures++;
            $display("FAIL collide_mem: a=%h b=%h required EE/EE", data_out_a, data_out_b);
        end
    endtask

    task automatic test_cross_write();
        drive_a(1'b1, 1'b1, 8'h06, 8'h11);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        drive_a(1'b1, 1'b1, 8'h06, 8'h22);
        drive_b(1'b1, 1'b0, 8'h06, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'h22 || data_out_b !== 8'h11) begin
            failures++;
            $display("FAIL a_wr_b_rd: a=%h b=%h required 22/11", data_out_a, data_out_b);
        end
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (data_out_b !== 8'h22) begin
            failures++;
            $display("FAIL b_reread: b=%h required 22", data_out_b);
        end
        // Mirror case: B writes while A reads the old word.
        drive_a(1'b1, 1'b1, 8'h07, 8'h44);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        drive_a(1'b1, 1'b0, 8'h07, 8'h00);
        drive_b(1'b1, 1'b1, 8'h07, 8'h55);
        tick();
        checks++;
        if (data_out_a !== 8'h44 || data_out_b !== 8'h55) begin
            failures++;
            $display("FAIL b_wr_a_rd: a=%h b=%h required 44/55", data_out_a, data_out_b);
        end
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'h55) begin
            failures++;
            $display("FAIL a_reread: a=%h required 55", data_out_a);
        end
    endtask

    task automatic test_enable_reset();
        // Outputs now a=55, b=55.
        drive_a(1'b0, 1'b1, 8'h06, 8'h99);
        drive_b(1'b0, 1'b1, 8'h06, 8'h98);
        tick();
        checks++;
        if (data_out_a !== 8'h55 || data_out_b !== 8'h55) begin
            failures++;
            $display("FAIL en_hold: a=%h b=%h required 55/55", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h06, 8'h00);
        drive_b(1'b1, 1'b0, 8'h06, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'h22 || data_out_b !== 8'h22) begin
            failures++;
            $display("FAIL en_nowrite: a=%h b=%h required 22/22", data_out_a, data_out_b);
        end
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 8'h01, 8'h55);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        rst = 1'b0;
        checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
            failures++;
            $display("FAIL midop_reset: a=%h b=%h required 00/00", data_out_a, data_out_b);
        end
        drive_a(1'b1, 1'b0, 8'h01, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hAA) begin
            failures++;
            $display("FAIL reset_keeps_mem: a=%h required AA", data_out_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        // A streams writes; B reads the word written on the previous cycle.
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b1, 8'h80 + 8'(i), 8'h30 + 8'(i));
            drive_b(i > 0, 1'b0, 8'h80 + 8'(i) - 8'h01, 8'h00);
            exp_b = (i > 0) ? 8'h30 + 8'(i) - 8'h01 : data_out_b;
            tick();
            checks++;
            if (data_out_a !== 8'h30 + 8'(i) || data_out_b !== exp_b) begin
                failures++;
                $display("FAIL b2b[%0d]: a=%h b=%h required %h/%h", i, data_out_a,
                         data_out_b, 8'h30 + 8'(i), exp_b);
            end
        end
        // Extremes of the address range.
        drive_a(1'b1, 1'b1, 8'hFF, 8'h5A);
        drive_b(1'b1, 1'b1, 8'h00, 8'hA5);
        tick();
        drive_a(1'b1, 1'b0, 8'h00, 8'h00);
        drive_b(1'b1, 1'b0, 8'hFF, 8'h00);
        tick();
        checks++;
        if (data_out_a !== 8'hA5 || data_out_b !== 8'h5A) begin
            failures++;
            $display("FAIL addr_edges: a=%h b=%h required A5/5A", data_out_a, data_out_b);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive_a(1'b0, 1'b0, 8'h00, 8'h00);
        drive_b(1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        test_reset();
        test_port_a();
        test_port_b();
        test_collision();
        test_cross_write();
        test_enable_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
